conv_weight_fetch: RTL



---
 rtl/conv_weight_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/conv_weight_fetch.sv
// Weight fetcher: streams packed 3x3 kernel words from the weight RAM to the conv engine.
// Define CONV_WEIGHT_FETCH_PREFETCH_EN for a 2-deep FIFO (1 word/cycle); otherwise 1-deep.
module conv_weight_fetch #(
    parameter int SIZE_1           = 11,
    parameter int SIZE_9           = 99,
    parameter int SIZE_address_wei = 11
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [SIZE_address_wei-1:0] base_addr,
    input  logic [SIZE_address_wei-1:0] count,
    output logic                        busy,
    output logic                        done,
    output logic                        re_wei,
    output logic [SIZE_address_wei-1:0] addr_wei,
    input  logic [SIZE_9-1:0]           q_wei,
    output logic                        w_valid,
    input  logic                        w_ready,
    output logic [SIZE_9-1:0]           w_data,
    output logic [SIZE_address_wei-1:0] w_index
);
`ifdef CONV_WEIGHT_FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    typedef logic [SIZE_address_wei-1:0] addr_t;

    if (SIZE_9 != 9 * SIZE_1) begin : g_size_chk
        $error("conv_weight_fetch: SIZE_9 must equal 9*SIZE_1");
    end

    logic [1:0]        state;
    addr_t             base_q, count_q, issued, out_cnt;
    logic              rd_pend;
    logic [SIZE_9-1:0] mem [2];
    logic              wr_ptr, rd_ptr;
    logic [1:0]        occ, occ_next, used;
    logic              pop, push;

    assign pop      = w_valid && w_ready;
    assign push     = rd_pend;
    assign occ_next = occ + {1'b0, push} - {1'b0, pop};
    // A slot being popped this cycle is already free for a new read; this is
    // what lets a 2-deep FIFO cover the RAM round trip at full rate.
    assign used     = occ + {1'b0, rd_pend} - {1'b0, pop};

    assign re_wei   = (state == FETCH) && (issued < count_q) && (used < 2'(DEPTH));
    assign addr_wei = re_wei ? addr_t'(base_q + issued) : '0;
    assign busy     = (state != IDLE);
    assign w_valid  = (occ != 2'd0);
    assign w_data   = mem[rd_ptr];
    assign w_index  = out_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            done    <= 1'b0;
            base_q  <= '0;
            count_q <= '0;
            issued  <= '0;
            out_cnt <= '0;
            rd_pend <= 1'b0;
            occ     <= '0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            done    <= 1'b0;
            occ     <= occ_next;
            rd_pend <= re_wei;
            if (push) begin
                mem[wr_ptr] <= q_wei;
                wr_ptr      <= (DEPTH == 2) ? ~wr_ptr : 1'b0;
            end
            if (pop) begin
                rd_ptr  <= (DEPTH == 2) ? ~rd_ptr : 1'b0;
                out_cnt <= out_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            base_q  <= base_addr;
                            count_q <= count;
                            issued  <= '0;
                            out_cnt <= '0;
                            state   <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (re_wei) begin
                        issued <= issued + 1'b1;
                        if (addr_t'(issued + 1'b1) == count_q) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // done lands the cycle after the final handshake edge
                    if (!rd_pend && occ_next == 2'd0) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
